// File: rtl/regfile_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_ctrl
// Brief    : Write-port owner for the register file: round-robin writeback
//            arbitration, zero-clear sequence, optional read bypass
//            (REGCTL_BYPASS_EN).
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_ctrl #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int DATA_W   = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              clear_start,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] dr0,
    input  logic [ADDR_W-1:0] dr1,
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              busy,
    output logic              LD_REG,
    output logic [ADDR_W-1:0] DR,
    output logic [DATA_W-1:0] D_in,
    input  logic [ADDR_W-1:0] SR1_in,
    input  logic [ADDR_W-1:0] SR2_in,
    input  logic [DATA_W-1:0] rf_sr1,
    input  logic [DATA_W-1:0] rf_sr2,
    output logic [DATA_W-1:0] SR1_out,
    output logic [DATA_W-1:0] SR2_out
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(NUM_REGS - 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_idx;
    logic                r_last;
    logic                r_ld;
    logic                r_gnt0;
    logic                r_gnt1;
    logic                r_busy;
    logic [ADDR_W-1:0]   r_dr;
    logic [DATA_W-1:0]   r_din;

    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   w_idx_nxt;
    logic                w_last_nxt;
    logic                w_ld_nxt;
    logic                w_gnt0_nxt;
    logic                w_gnt1_nxt;
    logic [ADDR_W-1:0]   w_dr_nxt;
    logic [DATA_W-1:0]   w_din_nxt;
    logic                w_elig0;
    logic                w_elig1;

    // A requester still seeing its grant has been served; ignore its held req.
    assign w_elig0 = req0 && !r_gnt0;
    assign w_elig1 = req1 && !r_gnt1;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= S_CLEAR;
            r_idx   <= '0;
            r_last  <= 1'b1;
            r_ld    <= 1'b0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_busy  <= 1'b1;
            r_dr    <= '0;
            r_din   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_last  <= w_last_nxt;
            r_ld    <= w_ld_nxt;
            r_gnt0  <= w_gnt0_nxt;
            r_gnt1  <= w_gnt1_nxt;
            r_busy  <= (w_state_nxt == S_CLEAR);
            r_dr    <= w_dr_nxt;
            r_din   <= w_din_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_last_nxt  = r_last;
        w_ld_nxt    = 1'b0;
        w_gnt0_nxt  = 1'b0;
        w_gnt1_nxt  = 1'b0;
        w_dr_nxt    = r_dr;
        w_din_nxt   = r_din;
        case (r_state)
            S_CLEAR: begin
                w_ld_nxt  = 1'b1;
                w_dr_nxt  = r_idx;
                w_din_nxt = '0;
                if (r_idx == c_last_idx) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            S_IDLE: begin
                if (clear_start) begin
                    w_state_nxt = S_CLEAR;
                    w_idx_nxt   = '0;
                end else if (w_elig0 && (!w_elig1 || r_last)) begin
                    // r_last=1 means requester 1 won most recently, so 0 takes a tie.
                    w_ld_nxt   = 1'b1;
                    w_gnt0_nxt = 1'b1;
                    w_dr_nxt   = dr0;
                    w_din_nxt  = d0;
                    w_last_nxt = 1'b0;
                end else if (w_elig1) begin
                    w_ld_nxt   = 1'b1;
                    w_gnt1_nxt = 1'b1;
                    w_dr_nxt   = dr1;
                    w_din_nxt  = d1;
                    w_last_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_CLEAR;
                w_idx_nxt   = '0;
            end
        endcase
    end

    assign gnt0   = r_gnt0;
    assign gnt1   = r_gnt1;
    assign busy   = r_busy;
    assign LD_REG = r_ld;
    assign DR     = r_dr;
    assign D_in   = r_din;

`ifdef REGCTL_BYPASS_EN
    // Forward the write being committed this cycle, including clear zeros.
    assign SR1_out = (r_ld && (r_dr == SR1_in)) ? r_din : rf_sr1;
    assign SR2_out = (r_ld && (r_dr == SR2_in)) ? r_din : rf_sr2;
`else
    logic w_unused_sr;
    assign w_unused_sr = ^{SR1_in, SR2_in};
    assign SR1_out     = rf_sr1;
    assign SR2_out     = rf_sr2;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_ctrl
// Brief    : Self-checking bench for regfile_write_ctrl (write scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_ctrl;

    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 16;
`ifdef REGCTL_BYPASS_EN
    localparam bit c_byp = 1'b1;
`else
    localparam bit c_byp = 1'b0;
`endif

    logic              Clk = 1'b0;
    logic              Reset, clear_start, req0, req1;
    logic [ADDR_W-1:0] dr0, dr1, DR, SR1_in, SR2_in;
    logic [DATA_W-1:0] d0, d1, D_in, rf_sr1, rf_sr2, SR1_out, SR2_out;
    logic              gnt0, gnt1, busy, LD_REG;

    always #5 Clk = ~Clk;

    regfile_write_ctrl #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .Clk(Clk), .Reset(Reset), .clear_start(clear_start),
        .req0(req0), .req1(req1), .dr0(dr0), .dr1(dr1), .d0(d0), .d1(d1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .LD_REG(LD_REG), .DR(DR), .D_in(D_in),
        .SR1_in(SR1_in), .SR2_in(SR2_in), .rf_sr1(rf_sr1), .rf_sr2(rf_sr2),
        .SR1_out(SR1_out), .SR2_out(SR2_out)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] dr;
        logic [DATA_W-1:0] d;
        logic              g0;
        logic              g1;
    } wr_t;

    typedef struct packed {
        logic              r0;
        logic              r1;
        logic [ADDR_W-1:0] dr0;
        logic [DATA_W-1:0] d0;
        logic [ADDR_W-1:0] dr1;
        logic [DATA_W-1:0] d1;
        logic              first1;
    } vec_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    vec_t vecs[7];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic push_wr(input logic [ADDR_W-1:0] dr, input logic [DATA_W-1:0] d,
                           input logic g0, input logic g1);
        wr_t e;
        e.dr = dr; e.d = d; e.g0 = g0; e.g1 = g1;
        exp_q.push_back(e);
    endtask

    task automatic push_clear();
        for (int r = 0; r < NUM_REGS; r++) push_wr(ADDR_W'(r), '0, 1'b0, 1'b0);
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge Clk);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge Clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ld"},   32'(LD_REG), 32'd0);
        check({tag, "_gnt"},  32'({gnt0, gnt1}), 32'd0);
        check({tag, "_dr"},   32'(DR), 32'd0);
        check({tag, "_din"},  32'(D_in), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    // Also plays the requester side: drop req once its grant is seen.
    always @(negedge Clk) begin
        if (LD_REG === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: DR=%0d D_in=%0h gnt=%b%b", DR, D_in, gnt0, gnt1);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_dr",   32'(DR), 32'(mon_e.dr));
                check("wr_data", 32'(D_in), 32'(mon_e.d));
                check("wr_gnt",  32'({gnt0, gnt1}), 32'({mon_e.g0, mon_e.g1}));
            end
        end
        if (gnt0 === 1'b1) req0 = 1'b0;
        if (gnt1 === 1'b1) req1 = 1'b0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        int n;
        Reset = 1'b0; clear_start = 1'b0; req0 = 1'b0; req1 = 1'b0;
        dr0 = '0; dr1 = '0; d0 = '0; d1 = '0;
        SR1_in = 3'd3; SR2_in = 3'd5; rf_sr1 = 16'hABCD; rf_sr2 = 16'h1234;

        // {r0, r1, dr0, d0, dr1, d1, first1}; arbiter history starts with last=1
        vecs[0] = '{1'b1, 1'b1, 3'd1, 16'h1111, 3'd2, 16'h2222, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 3'd3, 16'hBEEF, 3'd0, 16'h0000, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 3'd4, 16'hAAAA, 3'd5, 16'h5555, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 3'd0, 16'h0000, 3'd6, 16'h1234, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 3'd7, 16'h0F0F, 3'd7, 16'hF0F0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 3'd0, 16'h0000, 3'd0, 16'hFFFF, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 3'd2, 16'hCAFE, 3'd3, 16'h0001, 1'b0};

        // Reset and power-up clear
        @(negedge Clk); @(negedge Clk);
        check_reset_outputs("rst");
        check("rst_sr1_pass", 32'(SR1_out), 32'h0000ABCD);
        push_clear();
        Reset = 1'b1;
        busy_cnt = 1;
        for (int c = 0; c < 12; c++) begin
            @(negedge Clk);
            if (busy) busy_cnt++;
            if (LD_REG && DR == 3'd3)
                check("clr_bypass_sr1", 32'(SR1_out), c_byp ? 32'd0 : 32'h0000ABCD);
        end
        check("clear_busy_cycles", 32'(busy_cnt), 32'd8);
        check("clear_writes_left", 32'(exp_q.size()), 32'd0);
        check("clear_done_busy", 32'(busy), 32'd0);

        // Table-driven arbitration vectors
        for (int i = 0; i < 7; i++) begin
            req0 = vecs[i].r0; dr0 = vecs[i].dr0; d0 = vecs[i].d0;
            req1 = vecs[i].r1; dr1 = vecs[i].dr1; d1 = vecs[i].d1;
            if (vecs[i].r0 && vecs[i].r1) begin
                if (vecs[i].first1) begin
                    push_wr(vecs[i].dr1, vecs[i].d1, 1'b0, 1'b1);
                    push_wr(vecs[i].dr0, vecs[i].d0, 1'b1, 1'b0);
                end else begin
                    push_wr(vecs[i].dr0, vecs[i].d0, 1'b1, 1'b0);
                    push_wr(vecs[i].dr1, vecs[i].d1, 1'b0, 1'b1);
                end
            end else if (vecs[i].r0) begin
                push_wr(vecs[i].dr0, vecs[i].d0, 1'b1, 1'b0);
            end else begin
                push_wr(vecs[i].dr1, vecs[i].d1, 1'b0, 1'b1);
            end
            @(negedge Clk);
            check("vec_latency_ld", 32'(LD_REG), 32'd1);
            drain(8, "vec_drain");
        end

        // Idle: strobe low, index and data hold the last write
        check("hold_ld", 32'(LD_REG), 32'd0);
        check("hold_dr", 32'(DR), 32'd3);
        check("hold_din", 32'(D_in), 32'h0001);

        // Read bypass on a live write
        SR1_in = 3'd5; rf_sr1 = 16'h0000; SR2_in = 3'd5; rf_sr2 = 16'h1234;
        req0 = 1'b1; dr0 = 3'd5; d0 = 16'h00FF;
        push_wr(3'd5, 16'h00FF, 1'b1, 1'b0);
        @(negedge Clk);
        #1;
        check("byp_sr1", 32'(SR1_out), c_byp ? 32'h00FF : 32'h0000);
        check("byp_sr2", 32'(SR2_out), c_byp ? 32'h00FF : 32'h1234);
        drain(6, "byp_drain");
        check("byp_idle_sr1", 32'(SR1_out), 32'h0000);

        // clear_start beats a simultaneous request, which then waits
        clear_start = 1'b1;
        req1 = 1'b1; dr1 = 3'd2; d1 = 16'h2222;
        push_clear();
        push_wr(3'd2, 16'h2222, 1'b0, 1'b1);
        @(negedge Clk);
        clear_start = 1'b0;
        check("cs_busy", 32'(busy), 32'd1);
        check("cs_no_write", 32'(LD_REG), 32'd0);
        drain(16, "cs_drain");
        check("cs_busy_end", 32'(busy), 32'd0);

        // Reset in the middle of a clear restarts it from index 0
        Reset = 1'b0;
        @(negedge Clk);
        check_reset_outputs("rst2");
        exp_q.delete();
        push_clear();
        Reset = 1'b1;
        n = 0;
        while (!(LD_REG === 1'b1 && DR == 3'd4) && n < 20) begin
            @(negedge Clk);
            n++;
        end
        check("mid_reached_idx4", 32'(LD_REG && DR == 3'd4), 32'd1);
        Reset = 1'b0;
        @(negedge Clk);
        check_reset_outputs("mid_rst");
        exp_q.delete();
        push_clear();
        Reset = 1'b1;
        drain(16, "mid_restart");
        check("mid_done_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
